// File: rtl/tank_motion_sequencer.sv
// Per-frame movement, fire rate limiting and hit/explode/respawn life cycle
// for one player tank. Every output is driven directly from a flop.
module tank_motion_sequencer #(
   parameter int unsigned SPEED          = 2,
   parameter int unsigned X_MIN          = 0,
   parameter int unsigned X_MAX          = 608,
   parameter int unsigned Y_MIN          = 0,
   parameter int unsigned Y_MAX          = 448,
   parameter int unsigned SPAWN_X        = 304,
   parameter int unsigned SPAWN_Y        = 416,
   parameter int unsigned FIRE_COOLDOWN  = 30,
   parameter int unsigned EXPLODE_FRAMES = 16,
   parameter int unsigned RESPAWN_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       fire,
   input  logic       hit,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [1:0] direction,
   output logic [1:0] state,
   output logic       fire_pulse,
   output logic       fire_ready
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_MOVE    = 2'b01,
      ST_EXPLODE = 2'b10,
      ST_RESPAWN = 2'b11
   } state_t;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   // Bounds are held at 11 bits so that +/- SPEED never wraps during the compare.
   localparam logic [10:0] STEP       = 11'(SPEED);
   localparam logic [10:0] X_LO       = 11'(X_MIN);
   localparam logic [10:0] X_HI       = 11'(X_MAX);
   localparam logic [10:0] Y_LO       = 11'(Y_MIN);
   localparam logic [10:0] Y_HI       = 11'(Y_MAX);
   localparam logic [9:0]  SPAWN_X_V  = 10'(SPAWN_X);
   localparam logic [9:0]  SPAWN_Y_V  = 10'(SPAWN_Y);
   localparam logic [7:0]  COOLDOWN_V = 8'(FIRE_COOLDOWN);
   localparam logic [7:0]  EXPLODE_V  = 8'(EXPLODE_FRAMES);
   localparam logic [7:0]  RESPAWN_V  = 8'(RESPAWN_FRAMES);

   function automatic logic [9:0] sat_dec(input logic [9:0] p, input logic [10:0] lo);
      logic [10:0] pe;
      logic [10:0] res;
      pe = {1'b0, p};
      if (pe < lo + STEP) begin
         res = lo;
      end else begin
         res = pe - STEP;
      end
      return res[9:0];
   endfunction

   function automatic logic [9:0] sat_inc(input logic [9:0] p, input logic [10:0] hi);
      logic [10:0] pe;
      logic [10:0] res;
      pe = {1'b0, p};
      if (pe > hi - STEP) begin
         res = hi;
      end else begin
         res = pe + STEP;
      end
      return res[9:0];
   endfunction

   state_t     state_q, state_d;
   logic [9:0] pos_x_q, pos_x_d;
   logic [9:0] pos_y_q, pos_y_d;
   logic [1:0] dir_q, dir_d;
   logic       fire_pulse_q, fire_pulse_d;
   logic       fire_ready_q, fire_ready_d;
   logic [7:0] cooldown_q, cooldown_d;
   logic [7:0] life_q, life_d;

   logic [9:0] mv_x;
   logic [9:0] mv_y;
   logic [1:0] mv_dir;
   logic       any_btn;
   logic       alive;

   assign any_btn = up | down | left | right;
   assign alive   = (state_q == ST_IDLE) || (state_q == ST_MOVE);

   // Candidate position for this tick; only one axis moves, highest-priority button wins.
   always_comb begin : move_calc
      mv_x   = pos_x_q;
      mv_y   = pos_y_q;
      mv_dir = dir_q;
      if (up) begin
         mv_y   = sat_dec(pos_y_q, Y_LO);
         mv_dir = DIR_UP;
      end else if (down) begin
         mv_y   = sat_inc(pos_y_q, Y_HI);
         mv_dir = DIR_DOWN;
      end else if (left) begin
         mv_x   = sat_dec(pos_x_q, X_LO);
         mv_dir = DIR_LEFT;
      end else if (right) begin
         mv_x   = sat_inc(pos_x_q, X_HI);
         mv_dir = DIR_RIGHT;
      end
   end

   always_comb begin : next_state
      state_d      = state_q;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
      dir_d        = dir_q;
      life_d       = life_q;
      cooldown_d   = cooldown_q;
      fire_pulse_d = 1'b0;

      if (frame_tick && (cooldown_q != 8'd0)) begin
         cooldown_d = cooldown_q - 8'd1;
      end

      // A hit is taken on any clock and pre-empts everything a coincident tick would do.
      if (hit && alive) begin
         state_d = ST_EXPLODE;
         life_d  = EXPLODE_V;
      end else if (frame_tick) begin
         case (state_q)
            ST_IDLE, ST_MOVE: begin
               pos_x_d = mv_x;
               pos_y_d = mv_y;
               dir_d   = mv_dir;
               state_d = any_btn ? ST_MOVE : ST_IDLE;
               if (fire && (cooldown_q == 8'd0)) begin
                  fire_pulse_d = 1'b1;
                  cooldown_d   = COOLDOWN_V;
               end
            end
            ST_EXPLODE: begin
               life_d = life_q - 8'd1;
               if (life_q <= 8'd1) begin
                  state_d    = ST_RESPAWN;
                  pos_x_d    = SPAWN_X_V;
                  pos_y_d    = SPAWN_Y_V;
                  dir_d      = DIR_UP;
                  cooldown_d = 8'd0;
                  life_d     = RESPAWN_V;
               end
            end
            ST_RESPAWN: begin
               pos_x_d = mv_x;
               pos_y_d = mv_y;
               dir_d   = mv_dir;
               life_d  = life_q - 8'd1;
               if (life_q <= 8'd1) begin
                  state_d = ST_IDLE;
                  life_d  = 8'd0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      fire_ready_d = (cooldown_d == 8'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pos_x_q      <= SPAWN_X_V;
         pos_y_q      <= SPAWN_Y_V;
         dir_q        <= DIR_UP;
         fire_pulse_q <= 1'b0;
         fire_ready_q <= 1'b1;
         cooldown_q   <= 8'd0;
         life_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         dir_q        <= dir_d;
         fire_pulse_q <= fire_pulse_d;
         fire_ready_q <= fire_ready_d;
         cooldown_q   <= cooldown_d;
         life_q       <= life_d;
      end
   end

   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign direction  = dir_q;
   assign state      = state_q;
   assign fire_pulse = fire_pulse_q;
   assign fire_ready = fire_ready_q;

endmodule

// File: tb/tb_tank_motion_sequencer.sv
// Scoreboard bench for tank_motion_sequencer: stimulus queues hand-computed
// expectations, a monitor pops and compares one sample per marked clock.
module tb_tank_motion_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic       fire = 1'b0;
   logic       hit = 1'b0;
   logic [9:0] pos_x, pos_y, ob_x, ob_y;
   logic [1:0] direction, state, ob_dir, ob_state;
   logic       fire_pulse, fire_ready, ob_fp, ob_fr;

   always #5 clk = ~clk;

   tank_motion_sequencer dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .up(up), .down(down), .left(left), .right(right),
      .fire(fire), .hit(hit),
      .pos_x(pos_x), .pos_y(pos_y), .direction(direction), .state(state),
      .fire_pulse(fire_pulse), .fire_ready(fire_ready)
   );

   // Second instance spawning at an odd x so the clamp can be hit from x=1 and x=607.
   tank_motion_sequencer #(.SPAWN_X(1)) dut_odd (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .up(up), .down(down), .left(left), .right(right),
      .fire(fire), .hit(hit),
      .pos_x(ob_x), .pos_y(ob_y), .direction(ob_dir), .state(ob_state),
      .fire_pulse(ob_fp), .fire_ready(ob_fr)
   );

   typedef struct packed {
      logic       sel;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] dir;
      logic [1:0] st;
      logic       fp;
      logic       fr;
   } exp_t;

   exp_t  sb_q[$];
   string name_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   logic  chk_req = 1'b0;
   logic  chk_pend = 1'b0;

   always @(posedge clk) chk_pend <= chk_req;

   localparam logic [3:0] B_NONE = 4'b0000;
   localparam logic [3:0] B_U    = 4'b1000;
   localparam logic [3:0] B_D    = 4'b0100;
   localparam logic [3:0] B_L    = 4'b0010;
   localparam logic [3:0] B_R    = 4'b0001;

   // Monitor
   initial begin
      exp_t        e;
      string       nm;
      logic [25:0] act;
      logic [25:0] req;
      forever begin
         @(negedge clk);
         if (chk_pend) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_sample: DUT sampled with no queued expectation");
            end else begin
               e  = sb_q.pop_front();
               nm = name_q.pop_front();
               if (e.sel) act = {ob_x, ob_y, ob_dir, ob_state, ob_fp, ob_fr};
               else       act = {pos_x, pos_y, direction, state, fire_pulse, fire_ready};
               req = {e.x, e.y, e.dir, e.st, e.fp, e.fr};
               if (act !== req) begin
                  n_fail++;
                  $display("FAIL %s: got x=%0d y=%0d dir=%b st=%b fp=%b fr=%b, expected x=%0d y=%0d dir=%b st=%b fp=%b fr=%b",
                           nm, act[25:16], act[15:6], act[5:4], act[3:2], act[1], act[0],
                           e.x, e.y, e.dir, e.st, e.fp, e.fr);
               end else begin
                  $display("[TB] ok %s: x=%0d y=%0d dir=%b st=%b fp=%b fr=%b",
                           nm, e.x, e.y, e.dir, e.st, e.fp, e.fr);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_q.size());
      $fatal(1, "watchdog");
   end

   task automatic expect_push(input logic sel, input int x, input int y, input logic [1:0] d,
                              input logic [1:0] s, input logic fp, input logic fr, input string nm);
      exp_t e;
      e.sel = sel;
      e.x   = 10'(x);
      e.y   = 10'(y);
      e.dir = d;
      e.st  = s;
      e.fp  = fp;
      e.fr  = fr;
      sb_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic step(input logic tk, input logic [3:0] btn, input logic f, input logic h, input logic chk);
      @(negedge clk);
      frame_tick = tk;
      {up, down, left, right} = btn;
      fire    = f;
      hit     = h;
      chk_req = chk;
      @(negedge clk);
      frame_tick = 1'b0;
      hit        = 1'b0;
      chk_req    = 1'b0;
   endtask

   task automatic tick_chk(input logic [3:0] btn, input logic f, input logic h, input logic sel,
                           input int x, input int y, input logic [1:0] d, input logic [1:0] s,
                           input logic fp, input logic fr, input string nm);
      expect_push(sel, x, y, d, s, fp, fr, nm);
      step(1'b1, btn, f, h, 1'b1);
   endtask

   task automatic hold_chk(input logic [3:0] btn, input logic f, input logic h, input logic sel,
                           input int x, input int y, input logic [1:0] d, input logic [1:0] s,
                           input logic fp, input logic fr, input string nm);
      expect_push(sel, x, y, d, s, fp, fr, nm);
      step(1'b0, btn, f, h, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      frame_tick = 1'b0;
      {up, down, left, right} = B_NONE;
      fire = 1'b0;
      hit  = 1'b0;
      chk_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Raise rst shortly after a clock edge and sample before the next edge.
   task automatic rst_async_chk(input logic tk, input logic f, input string nm);
      expect_push(1'b0, 304, 416, 2'b00, 2'b00, 1'b0, 1'b1, nm);
      @(negedge clk);
      frame_tick = tk;
      {up, down, left, right} = B_NONE;
      fire    = f;
      hit     = 1'b0;
      chk_req = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      fire       = 1'b0;
      chk_req    = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic fp_e;
      logic fr_e;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset values
      hold_chk(B_NONE, 0, 0, 0, 304, 416, 2'b00, 2'b00, 0, 1, "reset_main");
      hold_chk(B_NONE, 0, 0, 1, 1,   416, 2'b00, 2'b00, 0, 1, "reset_odd");

      // movement, priority, direction hold
      tick_chk(B_U, 0, 0, 0, 304, 414, 2'b00, 2'b01, 0, 1, "up1");
      tick_chk(B_U, 0, 0, 0, 304, 412, 2'b00, 2'b01, 0, 1, "up2");
      tick_chk(B_U, 0, 0, 0, 304, 410, 2'b00, 2'b01, 0, 1, "up3");
      tick_chk(B_NONE, 0, 0, 0, 304, 410, 2'b00, 2'b00, 0, 1, "release_idle");
      hold_chk(B_U, 0, 0, 0, 304, 410, 2'b00, 2'b00, 0, 1, "between_ticks_hold");
      tick_chk(B_L, 0, 0, 0, 302, 410, 2'b10, 2'b01, 0, 1, "left");
      tick_chk(B_R, 0, 0, 0, 304, 410, 2'b11, 2'b01, 0, 1, "right");
      tick_chk(B_D | B_L, 0, 0, 0, 304, 412, 2'b01, 2'b01, 0, 1, "down_over_left");
      tick_chk(B_NONE, 0, 0, 0, 304, 412, 2'b01, 2'b00, 0, 1, "dir_holds");

      // clamping on x (odd instance) and y (main instance)
      do_reset();
      tick_chk(B_L, 0, 0, 1, 0, 416, 2'b10, 2'b01, 0, 1, "left_clamp_1to0");
      tick_chk(B_L, 0, 0, 1, 0, 416, 2'b10, 2'b01, 0, 1, "left_no_wrap");
      do_reset();
      for (int i = 0; i < 302; i++) step(1'b1, B_R, 1'b0, 1'b0, 1'b0);
      tick_chk(B_R, 0, 0, 1, 607, 416, 2'b11, 2'b01, 0, 1, "right_607");
      tick_chk(B_R, 0, 0, 1, 608, 416, 2'b11, 2'b01, 0, 1, "right_clamp_608");
      tick_chk(B_R, 0, 0, 0, 608, 416, 2'b11, 2'b01, 0, 1, "main_right_sat");
      for (int i = 0; i < 15; i++) step(1'b1, B_D, 1'b0, 1'b0, 1'b0);
      tick_chk(B_D, 0, 0, 0, 608, 448, 2'b01, 2'b01, 0, 1, "down_448");
      tick_chk(B_D, 0, 0, 0, 608, 448, 2'b01, 2'b01, 0, 1, "down_clamp");

      // held fire: pulses on ticks 1, 32, 63
      do_reset();
      for (int t = 1; t <= 70; t++) begin
         fp_e = (t == 1) || (t == 32) || (t == 63);
         fr_e = (t == 31) || (t == 62);
         tick_chk(B_NONE, 1, 0, 0, 304, 416, 2'b00, 2'b00, fp_e, fr_e, $sformatf("fire_t%0d", t));
         if (fp_e)
            hold_chk(B_NONE, 1, 0, 0, 304, 416, 2'b00, 2'b00, 0, 0, $sformatf("fire_width_t%0d", t));
      end

      // combined buttons with fire
      do_reset();
      tick_chk(B_U | B_R, 1, 0, 0, 304, 414, 2'b00, 2'b01, 1, 0, "up_right_fire");
      hold_chk(B_NONE, 0, 0, 0, 304, 414, 2'b00, 2'b01, 0, 0, "fire_one_clk");

      // hit / explode / respawn
      hold_chk(B_NONE, 0, 1, 0, 304, 414, 2'b00, 2'b10, 0, 0, "hit_midframe");
      tick_chk(B_U, 1, 0, 0, 304, 414, 2'b00, 2'b10, 0, 0, "explode_frozen1");
      for (int i = 0; i < 13; i++) step(1'b1, B_U, 1'b1, 1'b0, 1'b0);
      tick_chk(B_U, 1, 0, 0, 304, 414, 2'b00, 2'b10, 0, 0, "explode_t15");
      tick_chk(B_U, 1, 0, 0, 304, 416, 2'b00, 2'b11, 0, 1, "respawn_entry");
      hold_chk(B_NONE, 0, 1, 0, 304, 416, 2'b00, 2'b11, 0, 1, "hit_ignored_respawn");
      tick_chk(B_NONE, 1, 0, 0, 304, 416, 2'b00, 2'b11, 0, 1, "respawn_no_fire");
      tick_chk(B_U, 0, 0, 0, 304, 414, 2'b00, 2'b11, 0, 1, "respawn_move");
      for (int i = 0; i < 56; i++) step(1'b1, B_NONE, 1'b0, 1'b0, 1'b0);
      tick_chk(B_NONE, 0, 0, 0, 304, 414, 2'b00, 2'b11, 0, 1, "respawn_t59");
      tick_chk(B_NONE, 0, 0, 0, 304, 414, 2'b00, 2'b00, 0, 1, "respawn_done");
      tick_chk(B_NONE, 1, 0, 0, 304, 414, 2'b00, 2'b00, 1, 0, "fire_after_respawn");

      // hit coincident with tick, asynchronous reset
      do_reset();
      tick_chk(B_U, 1, 1, 0, 304, 416, 2'b00, 2'b10, 0, 1, "hit_wins_tick");
      tick_chk(B_NONE, 0, 0, 0, 304, 416, 2'b00, 2'b10, 0, 1, "explode_tick");
      rst_async_chk(1'b0, 1'b0, "async_rst_explode");
      tick_chk(B_NONE, 0, 0, 0, 304, 416, 2'b00, 2'b00, 0, 1, "post_reset_idle");
      rst_async_chk(1'b1, 1'b1, "async_rst_kills_fire");
      tick_chk(B_NONE, 1, 0, 0, 304, 416, 2'b00, 2'b00, 1, 0, "fire_after_rst");

      repeat (3) @(negedge clk);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tank_motion_sequencer.md
Name: tank_motion_sequencer

Overview:
- Per-frame sequencer for one player tank.
- Samples the button inputs on each frame tick and steps the tank position with playfield clamping.
- Rate-limits firing with a cooldown counter and runs the hit / explode / respawn life cycle.
- Sits between the debounced button inputs and the renderer/bullet logic; owns the registered tank position, direction and state.

Parameters:
- SPEED, 2, pixels moved per frame tick.
- X_MIN, 0, left bound of the tank's top-left x.
- X_MAX, 608, right bound (640 minus 32-px sprite).
- Y_MIN, 0, top bound.
- Y_MAX, 448, bottom bound (480 minus 32).
- SPAWN_X, 304, respawn x.
- SPAWN_Y, 416, respawn y.
- FIRE_COOLDOWN, 30, frame ticks between shots (1..255).
- EXPLODE_FRAMES, 16, ticks spent in EXPLODE (1..255).
- RESPAWN_FRAMES, 60, invulnerable ticks after respawn (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- frame_tick  in  1  one-clk pulse per video frame.
- up, down, left, right  in  1 each  button levels.
- fire  in  1  fire button level.
- hit  in  1  one-clk pulse: this tank was struck by a bullet.
- pos_x  out  10  tank top-left x.
- pos_y  out  10  tank top-left y.
- direction  out  2  facing: 00 up, 01 down, 10 left, 11 right.
- state  out  2  00 IDLE, 01 MOVE, 10 EXPLODE, 11 RESPAWN.
- fire_pulse  out  1  one-clk request to spawn a bullet at pos/direction.
- fire_ready  out  1  high when the cooldown counter is 0.

Behaviour:
- All outputs are registered.
- Reset values:
  - pos_x=SPAWN_X, pos_y=SPAWN_Y, direction=00.
  - state=IDLE, fire_pulse=0, fire_ready=1.
  - cooldown=0, life counter=0.
- All updates other than hit capture occur on the clock edge where frame_tick=1. Between ticks, pos/direction/state hold.
- Button priority: up > down > left > right.
  - Exactly one axis moves per tick.
  - direction takes the winning button's code.
  - With no button pressed, direction holds its last value.
- IDLE/MOVE on tick:
  - If any button is pressed: state=MOVE and pos steps by SPEED.
  - Otherwise: state=IDLE and pos holds.
- Clamping, saturating with no wrap-around:
  - up: pos_y = (pos_y < Y_MIN+SPEED) ? Y_MIN : pos_y-SPEED.
  - down: pos_y = (pos_y > Y_MAX-SPEED) ? Y_MAX : pos_y+SPEED.
  - x axis follows the same rule with X_MIN/X_MAX.
  - All comparisons are unsigned at 11 bits to avoid overflow.
- Fire, in IDLE/MOVE on a tick with fire=1 and cooldown==0:
  - fire_pulse=1 for exactly one clk (the cycle following the tick edge).
  - cooldown loads FIRE_COOLDOWN.
  - fire_pulse carries the post-move pos and direction.
- Cooldown:
  - cooldown decrements by 1 on each tick while nonzero, in every state.
  - fire_ready = (cooldown==0).
  - A held fire button fires again on the first tick at which cooldown has reached 0. That gives a period of FIRE_COOLDOWN+1 ticks.
- Hit:
  - hit is sampled every clk, not only on ticks.
  - In IDLE/MOVE: next clk gives state=EXPLODE, life counter=EXPLODE_FRAMES, and any pending fire_pulse is suppressed.
  - In EXPLODE/RESPAWN: hit is ignored.
- Hit and frame_tick on the same clk: hit wins. No move, no fire, state=EXPLODE.
- EXPLODE:
  - Inputs are ignored and pos is frozen.
  - life counter decrements per tick.
  - On the tick that it reaches 0: state=RESPAWN, pos=SPAWN_X/SPAWN_Y, direction=00, cooldown=0, life counter=RESPAWN_FRAMES.
- RESPAWN:
  - Movement follows the same rules as IDLE/MOVE.
  - Fire is blocked (no fire_pulse) and the tank is invulnerable.
  - life counter decrements per tick.
  - On the tick that it reaches 0: state=IDLE.
- rst asserted mid-operation immediately forces all reset values, including clearing any in-flight fire_pulse.

Test Plan:
1. Reset, then up held for 3 ticks → pos_y 416→414→412→410, direction=00, state=01. Release then 1 tick → state=00, pos hold.
2. pos_x=1, left for 1 tick → pos_x=0 (clamped). Another tick → still 0, no wrap. pos_x=607 with right → 608.
3. fire held over 70 ticks → fire_pulse on ticks 1, 32 and 63 only, each one clk wide. fire_ready low in between.
4. up+right+fire on one tick → only y moves, direction=00, and fire_pulse shows the post-move pos.
5. hit pulse mid-frame → state=10 on the next clk. After 16 ticks → state=11, pos=(304,416), direction=00. A hit during RESPAWN is ignored, and fire produces no pulse. After 60 more ticks → state=00.
6. hit coincident with frame_tick+fire+up → no move, no fire_pulse, state=10. rst asserted during EXPLODE → immediate return to reset values.
